// File: rtl/riscv_mem_scheduler.sv
// riscv_mem_scheduler: arbitrates the single main-memory request port between
// the icache and dcache. Icache-first priority with a starvation guard that
// forces the dcache after STARVE_LIMIT consecutive icache grants, grant hold
// until the memory accepts, a per-source cap on requests in flight, and
// tag-based response routing (tag 0 = icache, tag 1 = dcache).
// Optional feature macro: MEM_SCHED_PERF_EN adds grant/starvation counters.
module riscv_mem_scheduler #(
  parameter int STARVE_LIMIT    = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_BITS        = 2,
  parameter int MEM_ADDR_BITS   = 32,
  parameter int MEM_TAG_BITS    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ic_mem_req_valid,
  output logic                     ic_mem_req_ready,
  input  logic [MEM_ADDR_BITS-1:0] ic_mem_req_addr,
  output logic                     ic_mem_resp_valid,
  input  logic                     dc_mem_req_valid,
  output logic                     dc_mem_req_ready,
  input  logic                     dc_mem_req_rw,
  input  logic [MEM_ADDR_BITS-1:0] dc_mem_req_addr,
  output logic                     dc_mem_resp_valid,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_rw,
  output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  output logic [MEM_TAG_BITS-1:0]  mem_req_tag,
  input  logic                     mem_resp_valid,
`ifdef MEM_SCHED_PERF_EN
  output logic [31:0]              ic_grant_cnt,
  output logic [31:0]              dc_grant_cnt,
  output logic [15:0]              starve_cnt,
`endif
  input  logic [MEM_TAG_BITS-1:0]  mem_resp_tag
);

  // Counter widths never shrink below what the limits need, so a too-small
  // CNT_BITS cannot make the streak or outstanding limits unreachable.
  localparam int SW = (CNT_BITS > $clog2(STARVE_LIMIT + 1)) ?
                      CNT_BITS : $clog2(STARVE_LIMIT + 1);
  localparam int OW = (CNT_BITS > $clog2(MAX_OUTSTANDING + 1)) ?
                      CNT_BITS : $clog2(MAX_OUTSTANDING + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
  localparam logic [OW-1:0] OUT_MAX    = OW'(MAX_OUTSTANDING);
  localparam logic [MEM_TAG_BITS-1:0] TAG_IC = MEM_TAG_BITS'(0);
  localparam logic [MEM_TAG_BITS-1:0] TAG_DC = MEM_TAG_BITS'(1);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e          state_q, state_d;
  logic            owner_dc_q, owner_dc_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic [OW-1:0]   ic_out_q, ic_out_d;
  logic [OW-1:0]   dc_out_q, dc_out_d;

  logic ic_elig, dc_elig;
  logic grant_ic, grant_dc;
  logic ic_hs, dc_hs;
  logic ic_rsp, dc_rsp;

  // Control state register: FSM, hold owner, streak and outstanding counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_dc_q <= 1'b0;
      streak_q   <= '0;
      ic_out_q   <= '0;
      dc_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_dc_q <= owner_dc_d;
      streak_q   <= streak_d;
      ic_out_q   <= ic_out_d;
      dc_out_q   <= dc_out_d;
    end
  end

  // Winner selection and next state; HOLD forwards only the registered owner.
  always_comb begin
    ic_elig    = ic_mem_req_valid && (ic_out_q < OUT_MAX);
    dc_elig    = dc_mem_req_valid && (dc_out_q < OUT_MAX);
    grant_ic   = 1'b0;
    grant_dc   = 1'b0;
    state_d    = state_q;
    owner_dc_d = owner_dc_q;
    case (state_q)
      IDLE: begin
        if (dc_elig && ((streak_q == STREAK_MAX) || !ic_elig)) grant_dc = 1'b1;
        else if (ic_elig)                                      grant_ic = 1'b1;
        if ((grant_ic || grant_dc) && !mem_req_ready) begin
          state_d    = HOLD;
          owner_dc_d = grant_dc;
        end
      end
      HOLD: begin
        grant_dc = owner_dc_q && dc_mem_req_valid;
        grant_ic = !owner_dc_q && ic_mem_req_valid;
        // Leave on the owner's handshake, or if the owner dropped valid.
        if (!(grant_ic || grant_dc) || mem_req_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_valid    = grant_ic || grant_dc;
  assign mem_req_rw       = grant_dc ? dc_mem_req_rw : 1'b0;
  assign mem_req_addr     = grant_dc ? dc_mem_req_addr : ic_mem_req_addr;
  assign mem_req_tag      = grant_dc ? TAG_DC : TAG_IC;
  assign ic_mem_req_ready = grant_ic && mem_req_ready;
  assign dc_mem_req_ready = grant_dc && mem_req_ready;
  assign ic_hs            = ic_mem_req_ready;
  assign dc_hs            = dc_mem_req_ready;

  // Response routing depends only on the returned tag.
  assign ic_rsp            = mem_resp_valid && (mem_resp_tag == TAG_IC);
  assign dc_rsp            = mem_resp_valid && (mem_resp_tag == TAG_DC);
  assign ic_mem_resp_valid = ic_rsp;
  assign dc_mem_resp_valid = dc_rsp;

  // Streak and outstanding bookkeeping; a response at zero never underflows.
  always_comb begin
    streak_d = streak_q;
    if (dc_hs || !dc_mem_req_valid)       streak_d = '0;
    else if (ic_hs && (streak_q != STREAK_MAX)) streak_d = streak_q + SW'(1);

    ic_out_d = ic_out_q;
    if (ic_hs && !ic_rsp)                           ic_out_d = ic_out_q + OW'(1);
    else if (!ic_hs && ic_rsp && (ic_out_q != '0))  ic_out_d = ic_out_q - OW'(1);

    dc_out_d = dc_out_q;
    if (dc_hs && !dc_rsp)                           dc_out_d = dc_out_q + OW'(1);
    else if (!dc_hs && dc_rsp && (dc_out_q != '0))  dc_out_d = dc_out_q - OW'(1);
  end

`ifdef MEM_SCHED_PERF_EN
  logic        forced_q, forced_d;
  logic [31:0] ic_grant_cnt_q, ic_grant_cnt_d;
  logic [31:0] dc_grant_cnt_q, dc_grant_cnt_d;
  logic [15:0] starve_cnt_q, starve_cnt_d;

  // Performance counter registers; they wrap silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      forced_q       <= 1'b0;
      ic_grant_cnt_q <= '0;
      dc_grant_cnt_q <= '0;
      starve_cnt_q   <= '0;
    end else begin
      forced_q       <= forced_d;
      ic_grant_cnt_q <= ic_grant_cnt_d;
      dc_grant_cnt_q <= dc_grant_cnt_d;
      starve_cnt_q   <= starve_cnt_d;
    end
  end

  // A dcache win over an eligible icache is a forced grant; the flag is kept
  // while the grant is held so it is counted when the handshake lands.
  always_comb begin
    forced_d       = (state_q == IDLE) ? (grant_dc && ic_elig) : forced_q;
    ic_grant_cnt_d = ic_grant_cnt_q + (ic_hs ? 32'd1 : 32'd0);
    dc_grant_cnt_d = dc_grant_cnt_q + (dc_hs ? 32'd1 : 32'd0);
    starve_cnt_d   = starve_cnt_q + ((dc_hs && forced_d) ? 16'd1 : 16'd0);
  end

  assign ic_grant_cnt = ic_grant_cnt_q;
  assign dc_grant_cnt = dc_grant_cnt_q;
  assign starve_cnt   = starve_cnt_q;
`endif

endmodule
